// File: rtl/fault_filter_pkg.sv
// Shared definitions for the fault debounce array: per-channel FSM encoding
// and the helper that sizes the shared qualification counter.
package fault_filter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL_ON  = 2'd1,
    ACTIVE   = 2'd2,
    QUAL_OFF = 2'd3
  } fsm_state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Counter only has to reach max(assert, deassert) - 1; keep at least 1 bit.
  function automatic int cnt_width(input int a, input int d);
    int m;
    int w;
    m = (a > d) ? a : d;
    w = clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fault_debounce_array_glitch_channel.sv
// One debounce channel: optional synchroniser, hysteresis FSM with a shared
// qualification counter, registered filtered level and a rise strobe.
module glitch_channel
  import fault_filter_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int ASSERT_CNT   = 8,
  parameter int DEASSERT_CNT = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       noisy_i,
  output logic       fault_o,
  output logic       rise_o,
  output fsm_state_e state_o
);

  localparam int CW = cnt_width(ASSERT_CNT, DEASSERT_CNT);

  logic       s;
  fsm_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = noisy_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= noisy_i;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (s) begin
          if (ASSERT_CNT == 1) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else begin
            state_d = QUAL_ON;
            cnt_d   = CW'(1);
          end
        end
      end
      QUAL_ON: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(ASSERT_CNT - 1)) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ACTIVE: begin
        if (!s) begin
          if (DEASSERT_CNT == 1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = QUAL_OFF;
            cnt_d   = CW'(1);
          end
        end
      end
      default: begin
        if (s) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DEASSERT_CNT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // rise_o is high in the cycle before the edge where fault_o goes high, so the
  // top-level sticky/event logic updates on that same edge.
  always_comb begin
    fault_o = (state_q == ACTIVE) || (state_q == QUAL_OFF);
    rise_o  = !fault_o && (state_d == ACTIVE);
    state_o = state_q;
  end

endmodule

// File: rtl/fault_debounce_array.sv
// Multi-channel fault debouncer: per-channel filters plus sticky latches,
// a registered any-fault summary and a saturating rising-edge event counter.
module fault_debounce_array
  import fault_filter_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int ASSERT_CNT   = 8,
  parameter int DEASSERT_CNT = 4,
  parameter int EVT_W        = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   noisy_in,
  input  logic                  fault_clr,
  output logic [CHANNELS-1:0]   true_fault,
  output logic [CHANNELS-1:0]   fault_sticky,
  output logic                  any_fault,
  output logic [EVT_W-1:0]      event_count,
  output logic [2*CHANNELS-1:0] dbg_state_o
);

  localparam int PW = 6;
  localparam logic [EVT_W-1:0] EVT_MAX = '1;

  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] sticky_q, sticky_d;
  logic                any_q;
  logic [EVT_W-1:0]    evt_q, evt_d;
  logic [PW-1:0]       rise_cnt;
  logic [EVT_W+PW-1:0] evt_sum;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    fsm_state_e ch_state;
    glitch_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .ASSERT_CNT  (ASSERT_CNT),
      .DEASSERT_CNT(DEASSERT_CNT)
    ) u_ch (
      .clk_i  (clk),
      .rst_ni (reset),
      .noisy_i(noisy_in[g]),
      .fault_o(true_fault[g]),
      .rise_o (rise[g]),
      .state_o(ch_state)
    );
    assign dbg_state_o[2*g +: 2] = ch_state;
  end

  always_comb begin
    rise_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rise_cnt = rise_cnt + PW'(rise[i]);
    end
  end

  // Clear first, then OR in rises so a same-edge rise beats fault_clr.
  always_comb begin
    sticky_d = (fault_clr ? '0 : sticky_q) | rise;
    evt_sum  = {{PW{1'b0}}, evt_q} + {{EVT_W{1'b0}}, rise_cnt};
    evt_d    = (evt_sum > {{PW{1'b0}}, EVT_MAX}) ? EVT_MAX : evt_sum[EVT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sticky_q <= '0;
      any_q    <= 1'b0;
      evt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      any_q    <= |true_fault;
      evt_q    <= evt_d;
    end
  end

  assign fault_sticky = sticky_q;
  assign any_fault    = any_q;
  assign event_count  = evt_q;

endmodule

// File: tb/tb_fault_debounce_array.sv
// Bench for fault_debounce_array: scripted vector table, saturation sequence
// and randomized traffic, all checked against a run-length reference model.
module tb_fault_debounce_array;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int AC = 8;
  localparam int DC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [CH-1:0] noisy_in;
  logic          fault_clr;

  logic [CH-1:0] true_fault, fault_sticky, tf_s, st_s;
  logic          any_fault, any_s;
  logic [7:0]    event_count;
  logic [2:0]    event_count_s;
  logic [2*CH-1:0] dbg_state, dbg_state_s;

  fault_debounce_array #(.CHANNELS(CH), .SYNC_STAGES(SS), .ASSERT_CNT(AC),
                         .DEASSERT_CNT(DC), .EVT_W(8)) dut (
    .clk(clk), .reset(reset), .noisy_in(noisy_in), .fault_clr(fault_clr),
    .true_fault(true_fault), .fault_sticky(fault_sticky), .any_fault(any_fault),
    .event_count(event_count), .dbg_state_o(dbg_state)
  );

  fault_debounce_array #(.CHANNELS(CH), .SYNC_STAGES(SS), .ASSERT_CNT(AC),
                         .DEASSERT_CNT(DC), .EVT_W(3)) dut_s (
    .clk(clk), .reset(reset), .noisy_in(noisy_in), .fault_clr(fault_clr),
    .true_fault(tf_s), .fault_sticky(st_s), .any_fault(any_s),
    .event_count(event_count_s), .dbg_state_o(dbg_state_s)
  );

  // Reference model: input delay line, run length of samples disagreeing
  // with the filtered level, and plain counters.
  logic [CH-1:0] sync_m[SS];
  logic [CH-1:0] tf_m, sticky_m;
  logic          any_m;
  int            run_m[CH];
  int            evt_m, evt_s_m;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [CH-1:0] s;
    logic [CH-1:0] rises;
    int pc;
    if (!reset) begin
      for (int k = 0; k < SS; k++) sync_m[k] = '0;
      for (int c = 0; c < CH; c++) run_m[c] = 0;
      tf_m = '0; sticky_m = '0; any_m = 1'b0; evt_m = 0; evt_s_m = 0;
    end else begin
      s = sync_m[SS-1];
      rises = '0;
      any_m = |tf_m;
      for (int c = 0; c < CH; c++) begin
        if (s[c] != tf_m[c]) run_m[c]++;
        else run_m[c] = 0;
        if (!tf_m[c] && run_m[c] == AC) begin
          tf_m[c] = 1'b1; run_m[c] = 0; rises[c] = 1'b1;
        end else if (tf_m[c] && run_m[c] == DC) begin
          tf_m[c] = 1'b0; run_m[c] = 0;
        end
      end
      sticky_m = (fault_clr ? '0 : sticky_m) | rises;
      pc = $countones(rises);
      evt_m   = (evt_m + pc > 255) ? 255 : evt_m + pc;
      evt_s_m = (evt_s_m + pc > 7) ? 7 : evt_s_m + pc;
      for (int k = SS - 1; k > 0; k--) sync_m[k] = sync_m[k-1];
      sync_m[0] = noisy_in;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("true_fault", 32'(true_fault), 32'(tf_m));
    chk("fault_sticky", 32'(fault_sticky), 32'(sticky_m));
    chk("any_fault", 32'(any_fault), 32'(any_m));
    chk("event_count", 32'(event_count), 32'(evt_m));
    chk("event_count_sat", 32'(event_count_s), 32'(evt_s_m));
    chk("true_fault_small", 32'(tf_s), 32'(tf_m));
  endtask

  typedef struct {
    int            cycles;
    logic [CH-1:0] noisy;
    logic          clr;
    logic          rst_n;
    logic [CH-1:0] exp_tf;
    logic [CH-1:0] exp_sticky;
    logic          exp_any;
    logic [7:0]    exp_evt;
  } vec_t;

  vec_t vecs[$];
  logic [CH-1:0] cur;

  initial begin
    reset = 1'b0; noisy_in = 4'hF; fault_clr = 1'b0;

    //                 cyc noisy clr rst  tf   stky any evt
    vecs.push_back('{3,  4'hF, 0, 0, 4'h0, 4'h0, 0, 8'd0}); // reset hold
    vecs.push_back('{4,  4'h0, 0, 1, 4'h0, 4'h0, 0, 8'd0});
    vecs.push_back('{7,  4'h1, 0, 1, 4'h0, 4'h0, 0, 8'd0}); // glitch on ch0
    vecs.push_back('{6,  4'h0, 0, 1, 4'h0, 4'h0, 0, 8'd0});
    vecs.push_back('{9,  4'h2, 0, 1, 4'h0, 4'h0, 0, 8'd0}); // ch1 one short
    vecs.push_back('{1,  4'h2, 0, 1, 4'h2, 4'h2, 0, 8'd1}); // rises at 10
    vecs.push_back('{10, 4'h2, 0, 1, 4'h2, 4'h2, 1, 8'd1});
    vecs.push_back('{5,  4'h0, 0, 1, 4'h2, 4'h2, 1, 8'd1});
    vecs.push_back('{1,  4'h0, 0, 1, 4'h0, 4'h2, 1, 8'd1}); // falls at 6
    vecs.push_back('{10, 4'h4, 0, 1, 4'h4, 4'h6, 0, 8'd2}); // ch2 asserts
    vecs.push_back('{3,  4'h0, 0, 1, 4'h4, 4'h6, 1, 8'd2}); // hysteresis dip
    vecs.push_back('{6,  4'h4, 0, 1, 4'h4, 4'h6, 1, 8'd2});
    vecs.push_back('{6,  4'h0, 0, 1, 4'h0, 4'h6, 1, 8'd2});
    vecs.push_back('{1,  4'h0, 1, 1, 4'h0, 4'h0, 0, 8'd2}); // clear sticky
    vecs.push_back('{9,  4'hF, 0, 1, 4'h0, 4'h0, 0, 8'd2});
    vecs.push_back('{1,  4'hF, 1, 1, 4'hF, 4'hF, 0, 8'd6}); // rise beats clr
    vecs.push_back('{3,  4'hF, 0, 1, 4'hF, 4'hF, 1, 8'd6});
    vecs.push_back('{1,  4'hF, 1, 1, 4'hF, 4'h0, 1, 8'd6});
    vecs.push_back('{6,  4'h0, 0, 1, 4'h0, 4'h0, 1, 8'd6});
    vecs.push_back('{6,  4'h8, 0, 1, 4'h0, 4'h0, 0, 8'd6}); // ch3 mid-qualify
    vecs.push_back('{1,  4'h8, 0, 0, 4'h0, 4'h0, 0, 8'd0}); // reset there
    vecs.push_back('{9,  4'h8, 0, 1, 4'h0, 4'h0, 0, 8'd0});
    vecs.push_back('{1,  4'h8, 0, 1, 4'h8, 4'h8, 0, 8'd1}); // full requalify

    for (int v = 0; v < vecs.size(); v++) begin
      noisy_in  = vecs[v].noisy;
      fault_clr = vecs[v].clr;
      reset     = vecs[v].rst_n;
      for (int n = 0; n < vecs[v].cycles; n++) tick();
      chk($sformatf("vec%0d_tf", v), 32'(true_fault), 32'(vecs[v].exp_tf));
      chk($sformatf("vec%0d_sticky", v), 32'(fault_sticky), 32'(vecs[v].exp_sticky));
      chk($sformatf("vec%0d_any", v), 32'(any_fault), 32'(vecs[v].exp_any));
      chk($sformatf("vec%0d_evt", v), 32'(event_count), 32'(vecs[v].exp_evt));
    end

    // Saturation: 11 more rises; the 3-bit counter must pin at 7.
    fault_clr = 1'b0;
    for (int r = 0; r < 3; r++) begin
      noisy_in = 4'hF;
      for (int n = 0; n < 10; n++) tick();
      noisy_in = 4'h0;
      for (int n = 0; n < 6; n++) tick();
    end
    chk("sat_evt_small", 32'(event_count_s), 32'd7);
    chk("sat_evt_main", 32'(event_count), 32'd12);
    chk("sat_tf_released", 32'(true_fault), 32'd0);

    // Random traffic with long-ish runs, occasional clears and resets.
    cur = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 9) == 0) cur[c] = ~cur[c];
      end
      noisy_in  = cur;
      fault_clr = ($urandom_range(0, 15) == 0);
      reset     = !($urandom_range(0, 399) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
